// File: rtl/cpu_pc_pkg.sv
// Shared definitions for the program-counter front end.
//   SEL_*          : source-select encodings seen on pc_select_reg.sel
//   STEP_DEF       : default sequential PC increment
//   RESET_ADDR_DEF : default PC value after reset
//   pc_state_e     : redirect-buffer state (RUN = nothing pending, HOLD = redirect buffered)
package cpu_pc_pkg;

    localparam int SEL_SEQ = 0;
    localparam int SEL_IMM = 1;
    localparam int SEL_ALU = 2;

    localparam int          STEP_DEF       = 2;
    localparam logic [15:0] RESET_ADDR_DEF = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_e;

endpackage

// File: rtl/mux_n.sv
// Combinational WIDTH x NSRC binary-select multiplexer.
//   sel     : binary source index
//   data_in : flattened sources, source k is bits [k*WIDTH +: WIDTH]
//   y       : selected source; an index >= NSRC yields source 0
module mux_n #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 3,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        // Source 0 is the default, covering out-of-range indices without a latch.
        y = data_in[0 +: WIDTH];
        for (int k = 1; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                y = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_select_reg.sv
// Registered program counter with next-PC source selection.
// Picks pc+STEP or one of NSRC-1 redirect targets, holds on stall, buffers
// a redirect that arrives while stalled, and flags out-of-range selects.
//   clk, rst_n     : clock, synchronous active-low reset
//   stall          : hold the PC this cycle
//   sel            : 0 = sequential, k = targets slice k-1, >= NSRC illegal
//   targets        : flattened redirect targets, slice j = [j*WIDTH +: WIDTH]
//   pc             : current PC (registered)
//   pc_plus        : pc + STEP, combinational from pc only
//   redirect_taken : one-cycle pulse after a redirect target was loaded
//   sel_err        : sticky illegal-select flag, cleared only by reset
//   pend_valid     : a redirect is buffered awaiting stall release
module pc_select_reg
    import cpu_pc_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               NSRC       = 3,
    parameter int               SELW       = $clog2(NSRC),
    parameter int               STEP       = STEP_DEF,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_ADDR_DEF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic [SELW-1:0]           sel,
    input  logic [(NSRC-1)*WIDTH-1:0] targets,
    output logic [WIDTH-1:0]          pc,
    output logic [WIDTH-1:0]          pc_plus,
    output logic                      redirect_taken,
    output logic                      sel_err,
    output logic                      pend_valid
);

    // One extra bit so NSRC itself is representable when it is a power of two.
    localparam logic [SELW:0] NSRC_W = NSRC[SELW:0];

    pc_state_e        state, state_nxt;
    logic [WIDTH-1:0] pend_addr, pend_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic             rt_nxt;
    logic             sel_legal;
    logic             is_redir;
    logic [WIDTH-1:0] cand;

    assign pc_plus    = pc + WIDTH'(STEP);
    assign pend_valid = (state == HOLD);
    assign sel_legal  = ({1'b0, sel} < NSRC_W);
    assign is_redir   = sel_legal && (sel != SELW'(SEL_SEQ));

    // Illegal selects fall through to source 0, i.e. the sequential address.
    mux_n #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_mux (
        .sel     (sel),
        .data_in ({targets, pc_plus}),
        .y       (cand)
    );

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_addr;
        pc_nxt    = pc;
        rt_nxt    = 1'b0;
        unique case (state)
            RUN: begin
                if (!stall) begin
                    pc_nxt = cand;
                    rt_nxt = is_redir;
                end else if (is_redir) begin
                    pend_nxt  = cand;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    // Newest redirect replaces the buffered one.
                    if (is_redir) begin
                        pend_nxt = cand;
                    end
                end else begin
                    pc_nxt    = is_redir ? cand : pend_addr;
                    rt_nxt    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            pc             <= RESET_ADDR;
            pend_addr      <= '0;
            redirect_taken <= 1'b0;
            sel_err        <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            pend_addr      <= pend_nxt;
            redirect_taken <= rt_nxt;
            sel_err        <= sel_err | ~sel_legal;
        end
    end

endmodule

// File: tb/tb_pc_select_reg.sv
// Directed bench for pc_select_reg (WIDTH=16, NSRC=3, STEP=2, RESET_ADDR=0).
module tb_pc_select_reg;
    import cpu_pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] targets;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        redirect_taken;
    logic        sel_err;
    logic        pend_valid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] targets;   // {slice1, slice0}
        logic [15:0] pc;
        logic        rt;
        logic        pv;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    pc_select_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .sel            (sel),
        .targets        (targets),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .redirect_taken (redirect_taken),
        .sel_err        (sel_err),
        .pend_valid     (pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic st, input logic [1:0] s,
                       input logic [15:0] t1, input logic [15:0] t0,
                       input logic [15:0] p, input logic rt, input logic pv,
                       input logic err);
        vec_t v;
        v.rst_n = r; v.stall = st; v.sel = s; v.targets = {t1, t0};
        v.pc = p; v.rt = rt; v.pv = pv; v.err = err;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock, then compare away from the edge.
    task automatic step(input string tag, input vec_t v);
        rst_n   = v.rst_n;
        stall   = v.stall;
        sel     = v.sel;
        targets = v.targets;
        @(posedge clk);
        #1;
        check({tag, " pc"},         pc,                      v.pc);
        check({tag, " pc_plus"},    pc_plus,                 v.pc + 16'd2);
        check({tag, " redirect"},   16'(redirect_taken),     16'(v.rt));
        check({tag, " pend_valid"}, 16'(pend_valid),         16'(v.pv));
        check({tag, " sel_err"},    16'(sel_err),            16'(v.err));
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; stall = 1'b0; sel = 2'd0; targets = '0;
        #2;

        //   rst stall sel  slice1   slice0   pc       rt pv err
        add(0, 0, 0,       16'h0,   16'h0,   16'h0000, 0, 0, 0);  // reset
        add(0, 0, 0,       16'h0,   16'h0,   16'h0000, 0, 0, 0);
        add(1, 0, 0,       16'h0,   16'h0,   16'h0002, 0, 0, 0);  // sequential
        add(1, 0, 0,       16'h0,   16'h0,   16'h0004, 0, 0, 0);
        add(1, 0, 0,       16'h0,   16'h0,   16'h0006, 0, 0, 0);
        add(1, 0, SEL_IMM, 16'h0,   16'h0010, 16'h0010, 1, 0, 0); // move to 0x10
        add(1, 0, SEL_IMM, 16'h0,   16'h0100, 16'h0100, 1, 0, 0); // immediate redirect
        add(1, 0, 0,       16'h0,   16'h0,   16'h0102, 0, 0, 0);  // pulse ends
        add(1, 1, SEL_ALU, 16'h0ABC,16'h0,   16'h0102, 0, 1, 0);  // redirect under stall
        add(1, 0, 0,       16'h0,   16'h0,   16'h0ABC, 1, 0, 0);  // release
        add(1, 0, 0,       16'h0,   16'h0,   16'h0ABE, 0, 0, 0);
        add(1, 1, SEL_IMM, 16'h0,   16'h0200, 16'h0ABE, 0, 1, 0); // newest wins
        add(1, 1, SEL_ALU, 16'h0300,16'h0,   16'h0ABE, 0, 1, 0);
        add(1, 1, 0,       16'h0,   16'h0,   16'h0ABE, 0, 1, 0);  // sel 0 keeps pend
        add(1, 0, 0,       16'h0,   16'h0,   16'h0300, 1, 0, 0);
        add(1, 1, SEL_IMM, 16'h0,   16'h0200, 16'h0300, 0, 1, 0);
        add(1, 1, SEL_ALU, 16'h0300,16'h0,   16'h0300, 0, 1, 0);
        add(1, 0, SEL_IMM, 16'h0,   16'h0400, 16'h0400, 1, 0, 0); // new redirect overrides
        add(1, 1, 0,       16'h0,   16'h0,   16'h0400, 0, 0, 0);  // plain stall holds
        add(1, 0, SEL_IMM, 16'h0,   16'hFFFE, 16'hFFFE, 1, 0, 0);
        add(1, 0, 0,       16'h0,   16'h0,   16'h0000, 0, 0, 0);  // wrap
        add(1, 0, 3,       16'h1111,16'h2222, 16'h0002, 0, 0, 1); // illegal -> seq
        add(1, 0, 0,       16'h0,   16'h0,   16'h0004, 0, 0, 1);  // sticky
        add(1, 1, 3,       16'h0,   16'h0,   16'h0004, 0, 0, 1);  // illegal under stall
        add(1, 1, SEL_IMM, 16'h0,   16'h0500, 16'h0004, 0, 1, 1);
        add(1, 0, 3,       16'h0,   16'h0,   16'h0500, 1, 0, 1);  // illegal release uses pend

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a redirect is buffered: it must be discarded.
        v = '{rst_n:1, stall:1, sel:SEL_ALU, targets:{16'h0600, 16'h0}, pc:16'h0500, rt:0, pv:1, err:1};
        step("hold", v);
        v = '{rst_n:0, stall:0, sel:SEL_IMM, targets:{16'h0, 16'h0700}, pc:16'h0000, rt:0, pv:0, err:0};
        step("rst_mid_hold", v);
        v = '{rst_n:1, stall:0, sel:0, targets:{16'h0600, 16'h0700}, pc:16'h0002, rt:0, pv:0, err:0};
        step("post_rst1", v);
        step("post_rst2", '{rst_n:1, stall:0, sel:0, targets:'0, pc:16'h0004, rt:0, pv:0, err:0});

        // Long stall: buffered redirect survives many held cycles.
        step("ls0", '{rst_n:1, stall:1, sel:SEL_IMM, targets:{16'h0, 16'h1234}, pc:16'h0004, rt:0, pv:1, err:0});
        for (int i = 0; i < 4; i++) begin
            step($sformatf("ls_hold%0d", i), '{rst_n:1, stall:1, sel:0, targets:'0, pc:16'h0004, rt:0, pv:1, err:0});
        end
        step("ls_rel", '{rst_n:1, stall:0, sel:0, targets:'0, pc:16'h1234, rt:1, pv:0, err:0});
        step("ls_after", '{rst_n:1, stall:0, sel:0, targets:'0, pc:16'h1236, rt:0, pv:0, err:0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_select_reg.md
# pc_select_reg

Parametrised, registered successor to the CPU's next-PC selection multiplexers. It holds the program counter and chooses the next PC from an internal sequential increment or one of N-1 external redirect targets (branch/jump immediate, ALU result, …). It adds a stall hold, a pending-redirect buffer for redirects that arrive during a stall, and illegal-select detection. It sits between the decode/execute redirect sources and the instruction-memory address port.

## Interface
- WIDTH, 16: address width in bits.
- NSRC, 3: number of selectable sources, counting the internal sequential source; NSRC ≥ 2.
- SELW, $clog2(NSRC): select width, derived from NSRC, not overridden.
- STEP, 2: sequential increment added to the PC.
- RESET_ADDR, 16'h0000: PC value after reset.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  1 = hold the PC this cycle.
- sel  in  SELW  source select. 0 = PC+STEP; k = target slice k-1.
- targets  in  (NSRC-1)*WIDTH  flattened redirect targets; slice j is bits [j*WIDTH +: WIDTH].
- pc  out  WIDTH  registered current PC.
- pc_plus  out  WIDTH  combinational pc+STEP, modulo 2^WIDTH.
- redirect_taken  out  1  registered one-cycle pulse: the PC just loaded a redirect target.
- sel_err  out  1  registered sticky flag: an out-of-range sel was seen.
- pend_valid  out  1  registered: a redirect is buffered while stalled.

## Operation
- A redirect is any cycle with sel in 1..NSRC-1. Its target is targets slice sel-1.
- sel ≥ NSRC counts as illegal. It is treated as sel 0 and sets sel_err, which clears only on reset.
- The block has two states.
- State RUN, pend_valid=0:
  - stall=0: pc ← redirect target if sel≠0, else pc+STEP. redirect_taken ← 1 if a redirect was loaded.
  - stall=1 with a redirect: pc holds. pend_addr ← target, go to HOLD.
  - stall=1 with sel 0 or illegal: pc holds and no state change.
- State HOLD, pend_valid=1:
  - stall=1 with a new redirect: pend_addr ← new target. The newest redirect wins.
  - stall=1 with sel 0: pend_addr is kept.
  - stall=0 with a new redirect: pc ← the new target, which overrides pend_addr. Go to RUN, redirect_taken ← 1.
  - stall=0 with sel 0 or illegal: pc ← pend_addr, go to RUN, redirect_taken ← 1.
- redirect_taken is 0 in every cycle not listed above.
- The PC wraps: pc+STEP is computed modulo 2^WIDTH, and the carry is dropped with no flag.
- No output depends combinationally on sel or targets. pc_plus depends only on pc.

## Timing
- Reset values (rst_n=0 at a rising edge): pc=RESET_ADDR, pend_valid=0, pend_addr=0, redirect_taken=0, sel_err=0, state RUN. Reset overrides all other inputs.
- Reset mid-HOLD discards the pending redirect.
- Latency: sel/targets sampled at edge n appear on pc after edge n; that is, one cycle.
- A redirect buffered during a stall appears on pc one cycle after the first cycle with stall=0.
- There is no throughput limit. A new PC is possible every non-stalled cycle.
- There is no handshake. stall is level-sensitive and sampled each edge.

## Structure
- Shared package cpu_pc_pkg holds:
  - source encodings SEL_SEQ=0, SEL_IMM=1, SEL_ALU=2;
  - the default STEP and RESET_ADDR;
  - a state enum with RUN and HOLD.
- One sub-module, mux_n: a parametrised combinational WIDTH×NSRC binary-select mux with an explicit default, so no latch is inferred. It is instantiated once to pick the candidate next address.
- The state register, pend_addr, and the flags live in pc_select_reg.

## Test plan
- Reset then run: rst_n=0 for 2 cycles, then sel=0, stall=0 for 3 cycles. Required pc: 0x0000, 0x0002, 0x0004, 0x0006. redirect_taken stays 0.
- Immediate redirect: pc=0x0010, sel=1, targets slice0=0x0100. Next cycle pc=0x0100 and redirect_taken=1 for exactly one cycle.
- Redirect under stall: stall=1, sel=2, slice1=0x0ABC. pc holds and pend_valid=1. Then stall=0 with sel=0: pc=0x0ABC next cycle, pend_valid=0, redirect_taken=1.
- Newest-wins: during stall apply sel=1→0x0200, then sel=2→0x0300. Release stall with sel=0: pc=0x0300. Release with sel=1→0x0400 instead: pc=0x0400.
- Wrap and illegal select:
  - pc=0xFFFE, sel=0 gives pc=0x0000.
  - With NSRC=3, sel=3 gives pc+2 and sel_err=1, which stays set until rst_n=0.
- Reset mid-HOLD: pend_valid=1, then rst_n=0 for one edge. Required: pc=RESET_ADDR, pend_valid=0, and no redirect after release.
